// File: rtl/fp_mul_issue_unit.sv
// fp_mul_issue_unit: sequences IEEE-754 single-precision multiplies into a
// fixed-latency core that has no done output.
// Latency: accept -> core_start 1 cycle; core_start -> out_valid LATENCY+1 cycles.
// Backpressure: in_ready drops while an operation is in flight, and
// out_ready=0 holds the result and blocks new operands.
//
// Ports:
//   clk, reset                    clock (rising edge), async active-high reset
//   in_valid/in_ready/in_a/in_b   operand pair handshake
//   core_idle                     core controller idle flag (registered before use)
//   core_start/core_a/core_b      one-cycle start pulse and held operands to the core
//   core_result                   core product, sampled LATENCY cycles after start
//   out_valid/out_ready/out_result  result handshake
//   busy                          high whenever the unit is not idle
//
// Optional build macro: FP_MUL_ISSUE_ZERO_BYPASS_EN
//   When defined, finite zero operands produce a signed zero directly,
//   without using the core. Zero times Inf/NaN still goes through the core.
module fp_mul_issue_unit #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        core_idle,
  output logic        core_start,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic [31:0] core_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        core_a_q, core_a_d;
  logic [31:0]        core_b_q, core_b_d;
  logic [31:0]        out_result_q, out_result_d;
  logic               core_idle_q;
  logic               accept;
  logic               in_ready_c;

`ifdef FP_MUL_ISSUE_ZERO_BYPASS_EN
  logic a_zero, b_zero, a_special, b_special, zero_byp;

  // Exponent FF means Inf or NaN: zero times those must go through the
  // core so it can produce the NaN.
  assign a_zero    = (in_a[30:0] == 31'd0);
  assign b_zero    = (in_b[30:0] == 31'd0);
  assign a_special = (in_a[30:23] == 8'hFF);
  assign b_special = (in_b[30:23] == 8'hFF);
  assign zero_byp  = (a_zero | b_zero) & ~a_special & ~b_special;
`endif

  // Register core_idle so start never depends combinationally on it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_idle_q <= 1'b0;
    end else begin
      core_idle_q <= core_idle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      out_result_q <= out_result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    out_result_d = out_result_q;
    core_start   = 1'b0;
    in_ready_c   = 1'b0;
    out_valid    = 1'b0;
    accept       = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        accept     = in_valid;
      end

      S_ISSUE: begin
        // Start only when the core reports idle. This state is the only
        // place a start can be issued, so a start can never overlap an
        // operation that is already in flight.
        if (core_idle_q) begin
          core_start = 1'b1;
          cnt_d      = CNT_W'(LATENCY);
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The count started at LATENCY, so the cycle with count 1 is the
        // LATENCY-th cycle after start, when core_result is stable.
        if (cnt_q == CNT_W'(1)) begin
          out_result_d = core_result;
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        out_valid  = 1'b1;
        in_ready_c = out_ready;
        if (out_ready) begin
          // An operand pair that arrives in the same cycle as the result
          // handshake is taken at once, with no idle bubble in between.
          if (in_valid) begin
            accept = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      core_a_d = in_a;
      core_b_d = in_b;
      state_d  = S_ISSUE;
`ifdef FP_MUL_ISSUE_ZERO_BYPASS_EN
      if (zero_byp) begin
        out_result_d = {in_a[31] ^ in_b[31], 31'd0};
        state_d      = S_HOLD;
      end
`endif
    end
  end

  // Keep in_ready low while reset is asserted, so nothing looks acceptable
  // before the unit comes out of reset.
  assign in_ready   = in_ready_c & ~reset;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign out_result = out_result_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_mul_issue_unit.sv
module tb_fp_mul_issue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        core_idle;
  logic        core_start;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [31:0] core_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  fp_mul_issue_unit #(.LATENCY(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_idle(core_idle), .core_start(core_start),
    .core_a(core_a), .core_b(core_b), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .busy(busy)
  );

  // Core model: the product is presented only in the 4th cycle after start;
  // every other cycle shows a garbage value, so a capture that is early or
  // late returns the wrong result.
  function automatic logic [31:0] product(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3FC00000_40000000: product = 32'h40400000;
      64'hC0000000_40400000: product = 32'hC0C00000;
      64'h40000000_40000000: product = 32'h40800000;
      64'h00000000_7F800000: product = 32'h7FC00000;
      default:               product = 32'hDEADBEEF;
    endcase
  endfunction

  int          mcnt;
  logic [31:0] mval;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt <= 0;
      mval <= 32'h0;
    end else if (core_start) begin
      mcnt <= 4;
      mval <= product(core_a, core_b);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign core_result = (mcnt == 1) ? mval : 32'hBAD0BAD0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Called during the start cycle: counts cycles until out_valid rises and
  // checks that no second start appears meanwhile. Returns -1 on timeout.
  task automatic wait_out(output int cycles);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      nxt();
      #1;
      cycles++;
      if (out_valid) return;
      chk1("no_second_start", core_start, 1'b0);
    end
    cycles = -1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    core_idle = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_in_ready_low", in_ready, 1'b0);
    #1 reset = 1'b0;
    #1;
    chk1("idle_in_ready", in_ready, 1'b1);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_out_valid", out_valid, 1'b0);
    chk1("idle_core_start", core_start, 1'b0);
    chk32("idle_out_result", out_result, 32'h0);
    chk32("idle_core_a", core_a, 32'h0);

    // Basic multiply 1.5 x 2.0
    nxt();
    in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40000000;
    #1 chk1("basic_in_ready", in_ready, 1'b1);
    chk1("basic_no_early_start", core_start, 1'b0);
    nxt(); in_valid = 1'b0;
    #1 chk1("basic_start", core_start, 1'b1);
    chk1("basic_busy", busy, 1'b1);
    chk32("basic_core_a", core_a, 32'h3FC00000);
    chk32("basic_core_b", core_b, 32'h40000000);
    wait_out(n);
    chk32("basic_latency", 32'(n), 32'd5);
    chk32("basic_result", out_result, 32'h40400000);
    chk1("basic_hold_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    #1 chk1("basic_hold_in_ready_or", in_ready, 1'b1);
    nxt(); out_ready = 1'b0;
    #1 chk1("basic_back_idle_busy", busy, 1'b0);
    chk1("basic_back_idle_valid", out_valid, 1'b0);

    // Core busy stall: core_idle low for 3 cycles after accept
    core_idle = 1'b0; in_valid = 1'b1;
    nxt(); in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1 chk1("stall_no_start", core_start, 1'b0);
      chk1("stall_busy", busy, 1'b1);
      nxt();
    end
    core_idle = 1'b1;
    #1 chk1("stall_q_lag", core_start, 1'b0);
    nxt();
    #1 chk1("stall_start", core_start, 1'b1);
    wait_out(n);
    chk32("stall_latency", 32'(n), 32'd5);
    chk32("stall_result", out_result, 32'h40400000);
    out_ready = 1'b1;
    nxt(); out_ready = 1'b0;

    // Back-to-back: second pair handshakes in the same cycle as result 1
    in_valid = 1'b1;
    nxt(); in_valid = 1'b0;
    #1 chk1("b2b_start1", core_start, 1'b1);
    wait_out(n);
    chk32("b2b_result1", out_result, 32'h40400000);
    out_ready = 1'b1; in_valid = 1'b1; in_a = 32'hC0000000; in_b = 32'h40400000;
    #1 chk1("b2b_in_ready", in_ready, 1'b1);
    nxt(); in_valid = 1'b0; out_ready = 1'b0;
    #1 chk1("b2b_no_bubble_start", core_start, 1'b1);
    chk1("b2b_busy", busy, 1'b1);
    chk32("b2b_core_a", core_a, 32'hC0000000);
    wait_out(n);
    chk32("b2b_latency", 32'(n), 32'd5);
    chk32("b2b_result2", out_result, 32'hC0C00000);

    // Backpressure: out_ready low for 10 cycles, new operands must wait
    in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40000000;
    for (int i = 0; i < 10; i++) begin
      #1 chk1("bp_valid", out_valid, 1'b1);
      chk32("bp_result", out_result, 32'hC0C00000);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk32("bp_core_a_held", core_a, 32'hC0000000);
      nxt();
    end
    out_ready = 1'b1;
    #1 chk1("bp_release_in_ready", in_ready, 1'b1);
    nxt(); out_ready = 1'b0; in_valid = 1'b0;
    #1 chk1("bp_next_start", core_start, 1'b1);
    chk32("bp_next_core_a", core_a, 32'h40000000);
    nxt();
    #1 chk1("wait_busy", busy, 1'b1);
    nxt();
    // Reset in the middle of WAIT
    #2 reset = 1'b1;
    #1 chk1("rst_busy", busy, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_core_start", core_start, 1'b0);
    chk32("rst_core_a", core_a, 32'h0);
    chk32("rst_core_b", core_b, 32'h0);
    chk32("rst_out_result", out_result, 32'h0);
    nxt();
    #2 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nxt();
      #1 chk1("post_rst_no_start", core_start, 1'b0);
      chk1("post_rst_no_valid", out_valid, 1'b0);
    end
    chk1("post_rst_in_ready", in_ready, 1'b1);

`ifdef FP_MUL_ISSUE_ZERO_BYPASS_EN
    // -0 x 1.0 bypasses the core
    in_valid = 1'b1; in_a = 32'h80000000; in_b = 32'h3F800000;
    nxt(); in_valid = 1'b0;
    #1 chk1("byp_no_start", core_start, 1'b0);
    chk1("byp_valid", out_valid, 1'b1);
    chk32("byp_result", out_result, 32'h80000000);
    out_ready = 1'b1;
    nxt(); out_ready = 1'b0;
    // 0 x Inf goes through the core
    in_valid = 1'b1; in_a = 32'h00000000; in_b = 32'h7F800000;
    nxt(); in_valid = 1'b0;
    #1 chk1("zinf_start", core_start, 1'b1);
    wait_out(n);
    chk32("zinf_latency", 32'(n), 32'd5);
    chk32("zinf_result", out_result, 32'h7FC00000);
    out_ready = 1'b1;
    nxt(); out_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
